// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: Wishbone bus records, memory access sizes and
// data-bus controller state encodings, plus lane helpers for sub-word accesses.
package cpu_defs;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } WishboneReq_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } WishboneRes_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_INV  = 2'b11
  } MemSize_t;

  typedef logic [1:0] DbusState_t;
  localparam DbusState_t DBUS_IDLE = 2'd0;
  localparam DbusState_t DBUS_BUSY = 2'd1;
  localparam DbusState_t DBUS_DONE = 2'd2;

  function automatic logic [3:0] size_sel(input MemSize_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: size_sel = 4'b0001 << off;
      MEM_HALF: size_sel = 4'b0011 << {off[1], 1'b0};
      MEM_WORD: size_sel = 4'b1111;
      default:  size_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input MemSize_t size, input logic [31:0] wdata);
    case (size)
      MEM_BYTE: store_lanes = {4{wdata[7:0]}};
      MEM_HALF: store_lanes = {2{wdata[15:0]}};
      default:  store_lanes = wdata;
    endcase
  endfunction

  // Invalid size counts as a bad access so it never reaches the bus.
  function automatic logic access_bad(input MemSize_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: access_bad = 1'b0;
      MEM_HALF: access_bad = off[0];
      MEM_WORD: access_bad = (off != 2'b00);
      default:  access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_load_align.sv
// Load-path aligner: moves the addressed lane down to bit 0 and sign- or
// zero-extends it to 32 bits.
module dbus_load_align
  import cpu_defs::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  MemSize_t    size,
  input  logic        sgn,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = shifted;
    case (size)
      MEM_BYTE: result = {{24{sgn & shifted[7]}}, shifted[7:0]};
      MEM_HALF: result = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:  result = shifted;
    endcase
  end

endmodule

// File: rtl/dbus_ctrl.sv
// MEM-stage data bus controller: turns one pipeline load/store into a single
// Wishbone classic cycle, holding the pipeline until completion or error.
module dbus_ctrl
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_req,
  input  logic         mem_we,
  input  logic [1:0]   mem_size,
  input  logic         mem_signed,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  output logic         stall,
  output logic [31:0]  rdata,
  output logic         done,
  output logic         bus_err,
  output WishboneReq_t dbus_req,
  input  WishboneRes_t dbus_res
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  DbusState_t       state_reg;
  WishboneReq_t     req_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      rdata_reg;
  logic             err_reg;
  MemSize_t         size_reg;
  logic             sgn_reg;
  logic [1:0]       off_reg;

  MemSize_t    size_in;
  logic        bad_access;
  logic [31:0] load_value;

  assign size_in    = MemSize_t'(mem_size);
  assign bad_access = access_bad(size_in, mem_addr[1:0]);

  dbus_load_align u_align (
    .data   (dbus_res.data),
    .offset (off_reg),
    .size   (size_reg),
    .sgn    (sgn_reg),
    .result (load_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= DBUS_IDLE;
      req_reg   <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      size_reg  <= MEM_BYTE;
      sgn_reg   <= 1'b0;
      off_reg   <= 2'b00;
    end else begin
      case (state_reg)
        DBUS_IDLE: begin
          err_reg <= 1'b0;
          if (mem_req) begin
            if (bad_access) begin
              state_reg <= DBUS_DONE;
              err_reg   <= 1'b1;
              rdata_reg <= '0;
            end else begin
              state_reg    <= DBUS_BUSY;
              req_reg.cyc  <= 1'b1;
              req_reg.stb  <= 1'b1;
              req_reg.we   <= mem_we;
              req_reg.sel  <= size_sel(size_in, mem_addr[1:0]);
              req_reg.addr <= {mem_addr[31:2], 2'b00};
              req_reg.data <= store_lanes(size_in, mem_wdata);
              cnt_reg      <= '0;
              size_reg     <= size_in;
              sgn_reg      <= mem_signed;
              off_reg      <= mem_addr[1:0];
            end
          end
        end
        DBUS_BUSY: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (dbus_res.ack) begin
            state_reg   <= DBUS_DONE;
            req_reg.cyc <= 1'b0;
            req_reg.stb <= 1'b0;
            rdata_reg   <= req_reg.we ? '0 : load_value;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= DBUS_DONE;
            req_reg.cyc <= 1'b0;
            req_reg.stb <= 1'b0;
            err_reg     <= 1'b1;
            rdata_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DBUS_DONE: begin
          state_reg <= DBUS_IDLE;
          err_reg   <= 1'b0;
        end
        default: state_reg <= DBUS_IDLE;
      endcase
    end
  end

  assign stall    = mem_req & (state_reg != DBUS_DONE);
  assign done     = (state_reg == DBUS_DONE);
  assign bus_err  = err_reg;
  assign rdata    = rdata_reg;
  assign dbus_req = req_reg;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: a vector table of single accesses plus
// hand-written timeout, reset and handshake corner sequences.
module tb_dbus_ctrl;
  import cpu_defs::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req;
  logic         mem_we;
  logic [1:0]   mem_size;
  logic         mem_signed;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         stall;
  logic [31:0]  rdata;
  logic         done;
  logic         bus_err;
  WishboneReq_t dbus_req;
  WishboneRes_t dbus_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .rdata      (rdata),
    .done       (done),
    .bus_err    (bus_err),
    .dbus_req   (dbus_req),
    .dbus_res   (dbus_res)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_data;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_req    = 1'b1;
    mem_we     = we;
    mem_size   = size;
    mem_signed = sgn;
    mem_addr   = addr;
    mem_wdata  = wdata;
    dbus_res   = '0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 4'b1000, 32'h0, 32'h00000080};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 2'b00, 1'b0, 32'h001, 32'h11223355, 32'h0, 1'b0, 4'b0010, 32'h55555555, 32'h0};
    vecs[6] = '{1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h80011234, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001};
    vecs[7] = '{1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 2'b01, 1'b0, 32'h000, 32'h0, 32'h1234F00D, 1'b0, 4'b0011, 32'h0, 32'h0000F00D};

    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
    mem_addr = '0; mem_wdata = '0; dbus_res = '0;
    tick(); tick();
    chk("rst_cyc", {31'b0, dbus_req.cyc}, 32'd0);
    chk("rst_stb", {31'b0, dbus_req.stb}, 32'd0);
    chk("rst_we", {31'b0, dbus_req.we}, 32'd0);
    chk("rst_sel", {28'b0, dbus_req.sel}, 32'd0);
    chk("rst_addr", dbus_req.addr, 32'd0);
    chk("rst_data", dbus_req.data, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    $display("reset state checked");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      start(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_stall0", i), {31'b0, stall}, 32'd1);
      chk($sformatf("v%0d_cyc0", i), {31'b0, dbus_req.cyc}, 32'd0);
      tick();
      if (vecs[i].err) begin
        chk($sformatf("v%0d_done", i), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d_err", i), {31'b0, bus_err}, 32'd1);
        chk($sformatf("v%0d_nocyc", i), {31'b0, dbus_req.cyc}, 32'd0);
        chk($sformatf("v%0d_rdata", i), rdata, 32'd0);
        chk($sformatf("v%0d_stall1", i), {31'b0, stall}, 32'd0);
        mem_req = 1'b0;
      end else begin
        chk($sformatf("v%0d_cyc", i), {31'b0, dbus_req.cyc}, 32'd1);
        chk($sformatf("v%0d_stb", i), {31'b0, dbus_req.stb}, 32'd1);
        chk($sformatf("v%0d_we", i), {31'b0, dbus_req.we}, {31'b0, vecs[i].we});
        chk($sformatf("v%0d_sel", i), {28'b0, dbus_req.sel}, {28'b0, vecs[i].sel});
        chk($sformatf("v%0d_addr", i), dbus_req.addr, vecs[i].addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d_wdata", i), dbus_req.data, vecs[i].exp_wdata);
        chk($sformatf("v%0d_stall1", i), {31'b0, stall}, 32'd1);
        chk($sformatf("v%0d_busydone", i), {31'b0, done}, 32'd0);
        dbus_res.ack  = 1'b1;
        dbus_res.data = vecs[i].bus_data;
        tick();
        dbus_res = '0;
        chk($sformatf("v%0d_done", i), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d_err", i), {31'b0, bus_err}, 32'd0);
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d_cycoff", i), {31'b0, dbus_req.cyc}, 32'd0);
        chk($sformatf("v%0d_stall2", i), {31'b0, stall}, 32'd0);
        mem_req = 1'b0;
      end
      tick();
      chk($sformatf("v%0d_donepulse", i), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_errpulse", i), {31'b0, bus_err}, 32'd0);
      $display("vec %0d addr=%h size=%0d we=%0d rdata=%h", i, vecs[i].addr, vecs[i].size, vecs[i].we, rdata);
    end

    // Timeout: no ack for 4 BUSY cycles.
    start(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to_cyc%0d", k), {31'b0, dbus_req.cyc}, 32'd1);
      chk($sformatf("to_addr%0d", k), dbus_req.addr, 32'h300);
      chk($sformatf("to_done%0d", k), {31'b0, done}, 32'd0);
    end
    tick();
    chk("to_cycoff", {31'b0, dbus_req.cyc}, 32'd0);
    chk("to_done", {31'b0, done}, 32'd1);
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    mem_req = 1'b0;
    tick();
    chk("to_errpulse", {31'b0, bus_err}, 32'd0);
    $display("timeout sequence done");

    // Ack arriving on the final timeout cycle wins.
    start(1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("race_cyc%0d", k), {31'b0, dbus_req.cyc}, 32'd1);
    end
    tick();
    chk("race_cyc4", {31'b0, dbus_req.cyc}, 32'd1);
    dbus_res.ack  = 1'b1;
    dbus_res.data = 32'hCAFEF00D;
    tick();
    dbus_res = '0;
    chk("race_done", {31'b0, done}, 32'd1);
    chk("race_err", {31'b0, bus_err}, 32'd0);
    chk("race_rdata", rdata, 32'hCAFEF00D);
    mem_req = 1'b0;
    tick();
    $display("ack/timeout race done");

    // Reset during the second BUSY cycle, then a stray ack.
    start(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tick();
    chk("rb_cyc1", {31'b0, dbus_req.cyc}, 32'd1);
    tick();
    chk("rb_cyc2", {31'b0, dbus_req.cyc}, 32'd1);
    rst = 1'b0;
    mem_req = 1'b0;
    tick();
    chk("rb_cycoff", {31'b0, dbus_req.cyc}, 32'd0);
    chk("rb_done", {31'b0, done}, 32'd0);
    rst = 1'b1;
    dbus_res.ack  = 1'b1;
    dbus_res.data = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("rb_stray_done%0d", k), {31'b0, done}, 32'd0);
      chk($sformatf("rb_stray_cyc%0d", k), {31'b0, dbus_req.cyc}, 32'd0);
    end
    dbus_res = '0;
    $display("reset-in-busy sequence done");

    // mem_req withdrawn mid-BUSY: cycle completes, stall reads 0.
    start(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    tick();
    mem_req = 1'b0;
    #1;
    chk("drop_stall", {31'b0, stall}, 32'd0);
    chk("drop_cyc", {31'b0, dbus_req.cyc}, 32'd1);
    dbus_res.ack  = 1'b1;
    dbus_res.data = 32'h11112222;
    tick();
    dbus_res = '0;
    chk("drop_done", {31'b0, done}, 32'd1);
    chk("drop_rdata", rdata, 32'h11112222);
    tick();
    $display("req-drop sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
